// File: rtl/stream_demux_n.sv
// stream_demux_n
//   Registered 1-to-N stream demultiplexer. An input word is routed to one
//   of N output channels, chosen by in_sel, or to every channel when
//   in_bcast is set. Each channel owns a one-entry output register, so a
//   word appears on its channel one cycle after it is accepted. Upstream
//   backpressure is computed per channel, so a stalled channel only blocks
//   words that need it. Words whose select is outside 0..N-1 are accepted
//   and discarded, and they are counted in a saturating drop counter.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   block accepts the word this cycle (combinational)
//   in_data    input word, DW bits
//   in_sel     destination channel index, SW bits
//   in_bcast   write the word to all N channels and ignore in_sel
//   out_valid  per-channel word-held flags, N bits
//   out_ready  per-channel consumer ready, N bits
//   out_data   channel k occupies bits [k*DW +: DW]
//   drop_cnt   saturating count of out-of-range words
module stream_demux_n #(
  parameter int DW = 8,
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [SW-1:0]   in_sel,
  input  logic            in_bcast,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*DW-1:0] out_data,
  output logic [7:0]      drop_cnt
);

  // N held in one extra bit so the range compare works for any legal SW.
  localparam logic [SW:0] NUM_CH = (SW+1)'(N);

  logic [N-1:0]  valid_q;
  logic [DW-1:0] slot_data [N];
  logic [N-1:0]  free;
  logic [N-1:0]  load;
  logic          sel_in_range;
  logic          sel_free;
  logic          xfer;
  logic          drop_event;
  logic [7:0]    drop_q;

  assign sel_in_range = ({1'b0, in_sel} < NUM_CH);

  // A slot can take a new word if it is empty or is being drained this cycle.
  assign free = ~valid_q | out_ready;

  // Pick the free flag of the addressed slot by comparison rather than by
  // indexing, so a select wider than the channel count never indexes past
  // the end of the vector.
  always_comb begin
    sel_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SW'(k)) begin
        sel_free = free[k];
      end
    end
  end

  // Broadcast needs every slot; an out-of-range word is always taken
  // because it is simply dropped.
  always_comb begin
    if (in_bcast) begin
      in_ready = &free;
    end else if (sel_in_range) begin
      in_ready = sel_free;
    end else begin
      in_ready = 1'b1;
    end
  end

  assign xfer       = in_valid & in_ready;
  assign drop_event = xfer & ~in_bcast & ~sel_in_range;

  // One register slot per channel. A reload on the same edge as a drain
  // wins, which keeps the channel at one word per cycle.
  for (genvar k = 0; k < N; k++) begin : g_slot
    assign load[k] = xfer & (in_bcast | (in_sel == SW'(k)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[k]   <= 1'b0;
        slot_data[k] <= '0;
      end else if (load[k]) begin
        valid_q[k]   <= 1'b1;
        slot_data[k] <= in_data;
      end else if (out_ready[k]) begin
        valid_q[k]   <= 1'b0;
      end
    end

    assign out_data[k*DW +: DW] = slot_data[k];
  end

  // Drop counter sticks at its maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 8'd0;
    end else if (drop_event && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign out_valid = valid_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n
//   Self-checking bench for stream_demux_n with N=8, DW=8 and a 4-bit select
//   so that selects 8..15 are out of range. A behavioural model of the
//   channel contents (plain arrays plus a drop count) predicts in_ready,
//   out_valid, out_data and drop_cnt for directed and random traffic.
module tb_stream_demux_n;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int SW = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_sel;
  logic            in_bcast;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*DW-1:0] out_data;
  logic [7:0]      drop_cnt;

  int testCount;
  int failCount;

  // Reference model state: which channels hold a word, what they hold,
  // and how many words were dropped.
  bit        mValid [N];
  logic [7:0] mData [N];
  int        mDrop;

  stream_demux_n #(.DW(DW), .N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] modelValidVec();
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k] = mValid[k];
    return v;
  endfunction

  // Compare every visible output against the model.
  task automatic checkModelOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(modelValidVec()));
    checkOutput({tag, "_drop"}, 32'(drop_cnt), 32'(mDrop));
    for (int k = 0; k < N; k++) begin
      if (mValid[k]) checkOutput({tag, "_data"}, 32'(out_data[k*DW +: DW]), 32'(mData[k]));
    end
  endtask

  // Drive one cycle of input, check in_ready against the model before the
  // edge, advance the model across the edge, then check outputs.
  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [SW-1:0] sel, input logic bc,
                               input logic [7:0] data, input logic [N-1:0] rdy,
                               input string tag);
    bit expReady;
    bit allFree;
    bit xfer;
    int s;
    in_valid  = v;
    in_sel    = sel;
    in_bcast  = bc;
    in_data   = data;
    out_ready = rdy;
    s = int'(sel);
    allFree = 1'b1;
    for (int k = 0; k < N; k++) if (mValid[k] && !rdy[k]) allFree = 1'b0;
    if (bc)          expReady = allFree;
    else if (s < N)  expReady = !mValid[s] || rdy[s];
    else             expReady = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'(expReady));
    xfer = v && expReady;
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (xfer && (bc || s == k)) begin
        mValid[k] = 1'b1;
        mData[k]  = data;
      end else if (mValid[k] && rdy[k]) begin
        mValid[k] = 1'b0;
      end
    end
    if (xfer && !bc && s >= N && mDrop < 255) mDrop++;
    #1;
    checkModelOutputs(tag);
  endtask

  task automatic modelReset();
    for (int k = 0; k < N; k++) begin
      mValid[k] = 1'b0;
      mData[k]  = 8'h00;
    end
    mDrop = 0;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    modelReset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_bcast  = 1'b0;
    in_data   = '0;
    out_ready = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_data", 32'(out_data), 32'h0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two unicast words on consecutive cycles, all consumers ready.
    applyStimulus(1'b1, 4'd3, 1'b0, 8'hA5, 8'hFF, "uni1");
    checkOutput("uni1_vec", 32'(out_valid), 32'h08);
    checkOutput("uni1_ch3", 32'(out_data[3*DW +: DW]), 32'hA5);
    applyStimulus(1'b1, 4'd7, 1'b0, 8'h5A, 8'hFF, "uni2");
    checkOutput("uni2_vec", 32'(out_valid), 32'h80);
    checkOutput("uni2_ch7", 32'(out_data[7*DW +: DW]), 32'h5A);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 8'hFF, "idle1");

    // Channel 2 stalled: second word waits, channel 5 still flows.
    applyStimulus(1'b1, 4'd2, 1'b0, 8'h11, 8'hFB, "stall_a");
    applyStimulus(1'b1, 4'd2, 1'b0, 8'h22, 8'hFB, "stall_b");
    checkOutput("stall_b_rdy", 32'(in_ready), 32'h0);
    checkOutput("stall_hold", 32'(out_data[2*DW +: DW]), 32'h11);
    applyStimulus(1'b1, 4'd5, 1'b0, 8'h55, 8'hFB, "stall_c");
    checkOutput("stall_hold2", 32'(out_data[2*DW +: DW]), 32'h11);
    applyStimulus(1'b1, 4'd2, 1'b0, 8'h22, 8'hFF, "stall_d");
    checkOutput("stall_d_ch2", 32'(out_data[2*DW +: DW]), 32'h22);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 8'hFF, "idle2");

    // Full-throughput stream into channel 0.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'd0, 1'b0, 8'(i), 8'hFF, "stream");
      checkOutput("stream_v0", 32'(out_valid[0]), 32'h1);
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 8'hFF, "idle3");

    // Broadcast blocked by a full, stalled slot 6.
    applyStimulus(1'b1, 4'd6, 1'b0, 8'h77, 8'hBF, "bc_fill");
    applyStimulus(1'b1, 4'd1, 1'b1, 8'h3C, 8'hBF, "bc_block");
    checkOutput("bc_block_vec", 32'(out_valid), 32'h40);
    applyStimulus(1'b1, 4'd1, 1'b1, 8'h3C, 8'hFF, "bc_go");
    checkOutput("bc_go_vec", 32'(out_valid), 32'hFF);
    for (int k = 0; k < N; k++) checkOutput("bc_data", 32'(out_data[k*DW +: DW]), 32'h3C);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 8'hFF, "idle4");

    // Asynchronous reset with channels 2 and 5 full and five drops counted.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'd12, 1'b0, 8'h99, 8'hFF, "pre_drop");
    applyStimulus(1'b1, 4'd2, 1'b0, 8'h12, 8'h00, "pre_a");
    applyStimulus(1'b1, 4'd5, 1'b0, 8'h15, 8'h00, "pre_b");
    checkOutput("pre_vec", 32'(out_valid), 32'h24);
    checkOutput("pre_drop_cnt", 32'(drop_cnt), 32'd5);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'h0);
    checkOutput("arst_drop", 32'(drop_cnt), 32'h0);
    modelReset();
    in_valid  = 1'b1;
    in_sel    = 4'd1;
    in_bcast  = 1'b0;
    in_data   = 8'hEE;
    out_ready = 8'h00;
    @(posedge clk);
    #1;
    checkOutput("arst_noxfer", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // That edge was after release with in_valid still high, so it transferred.
    mValid[1] = 1'b1;
    mData[1]  = 8'hEE;
    checkModelOutputs("post_rst");
    applyStimulus(1'b1, 4'd4, 1'b0, 8'h44, 8'hFF, "resume");
    checkOutput("resume_ch4", 32'(out_data[4*DW +: DW]), 32'h44);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 8'hFF, "idle5");

    // Out-of-range words saturate the drop counter without touching slots.
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 4'd9, 1'b0, 8'($urandom), 8'hFF, "drop");
      checkOutput("drop_vec", 32'(out_valid), 32'h0);
    end
    checkOutput("drop_sat", 32'(drop_cnt), 32'd255);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, 4'($urandom_range(0, 9)), ($urandom % 8) == 0,
                    8'($urandom), 8'($urandom | $urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
